// File: rtl/load_refill_buffer_if.sv
// Bundles the miss-enqueue, refill, flush and load-queue refill signals of load_refill_buffer.
// The slave modport is the buffer's view; master is the surrounding pipeline/testbench view.
interface load_refill_buffer_if #(
    parameter int PIPE         = 2,
    parameter int REFILL_PORTS = 2,
    parameter int LQ_W         = 5,
    parameter int ADDR_W       = 32,
    parameter int LINE_WORDS   = 16
);
    logic [PIPE-1:0]                   miss_en;
    logic [PIPE*(LQ_W+1)-1:0]          miss_lqidx;
    logic [PIPE*ADDR_W-1:0]            miss_paddr;
    logic [PIPE-1:0]                   miss_ack;
    logic                              refill_valid;
    logic                              refill_ready;
    logic [ADDR_W-7:0]                 refill_addr;
    logic [LINE_WORDS*32-1:0]          refill_data;
    logic                              flush_en;
    logic [LQ_W:0]                     flush_lqidx;
    logic [REFILL_PORTS-1:0]           lq_en;
    logic [REFILL_PORTS*(LQ_W+1)-1:0]  lq_idx;
    logic [REFILL_PORTS*32-1:0]        lq_data;
    logic                              full;

    modport master (
        output miss_en, miss_lqidx, miss_paddr, refill_valid, refill_addr, refill_data,
               flush_en, flush_lqidx,
        input  miss_ack, refill_ready, lq_en, lq_idx, lq_data, full
    );

    modport slave (
        input  miss_en, miss_lqidx, miss_paddr, refill_valid, refill_addr, refill_data,
               flush_en, flush_lqidx,
        output miss_ack, refill_ready, lq_en, lq_idx, lq_data, full
    );
endinterface

// File: rtl/load_refill_buffer.sv
// Holds DCache-missed loads until their line refills, then returns each load's word to the load queue.
// Optional LRB_PERF_CNT_EN adds saturating perf_refills / perf_nack counters.
module load_refill_buffer #(
    parameter int ENTRIES      = 8,
    parameter int PIPE         = 2,
    parameter int REFILL_PORTS = 2,
    parameter int LQ_W         = 5,
    parameter int ADDR_W       = 32,
    parameter int LINE_WORDS   = 16
) (
    input  logic                clk,
    input  logic                rst,
    load_refill_buffer_if.slave bus
`ifdef LRB_PERF_CNT_EN
    ,
    output logic [31:0]         perf_refills,
    output logic [31:0]         perf_nack
`endif
);
    localparam int IW = LQ_W + 1;
    localparam int LW = ADDR_W - 6;
    localparam int EW = $clog2(ENTRIES);
    localparam int WW = $clog2(LINE_WORDS);

    typedef enum logic {IDLE, DRAIN} state_t;
    state_t state, state_nxt;

    logic [ENTRIES-1:0] valid, valid_nxt, pend, pend_nxt;
    logic [IW-1:0]      e_lqidx [ENTRIES];
    logic [LW-1:0]      e_line  [ENTRIES];
    logic [WW-1:0]      e_word  [ENTRIES];
    logic [LW-1:0]      cur_line;
    logic [31:0]        line_buf [LINE_WORDS];

    logic [LW-1:0]      cmp_line;
    logic [LW-1:0]      port_line [PIPE];
    logic [PIPE-1:0]    ack;
    logic [EW-1:0]      alloc_idx [PIPE];
    logic [ENTRIES-1:0] alloc_any, new_match, line_hit, squash, emit_mask;
    logic [REFILL_PORTS-1:0] emit_en;
    logic [EW-1:0]      emit_idx [REFILL_PORTS];
    logic               hs;

    logic [REFILL_PORTS-1:0] lq_en_p1;
    logic [IW-1:0]      lq_idx_p1  [REFILL_PORTS];
    logic [31:0]        lq_data_p1 [REFILL_PORTS];
    logic               full_p1;
    logic [2*PIPE-1:0]  unused_paddr_lo;

    // Ring-order age compare: an entry is younger-or-equal to the flush point.
    function automatic logic is_squashed(input logic [IW-1:0] e, input logic [IW-1:0] f);
        if (e[LQ_W] != f[LQ_W]) return e[LQ_W-1:0] < f[LQ_W-1:0];
        else                    return e[LQ_W-1:0] >= f[LQ_W-1:0];
    endfunction

    for (genvar p = 0; p < PIPE; p++) begin : g_port
        assign port_line[p] = bus.miss_paddr[p*ADDR_W+6 +: LW];
        assign unused_paddr_lo[2*p +: 2] = bus.miss_paddr[p*ADDR_W +: 2];
    end

    assign hs       = (state == IDLE) && bus.refill_valid;
    assign cmp_line = (state == IDLE) ? bus.refill_addr : cur_line;

    // Allocation: each requesting port in order takes the lowest still-free entry.
    always_comb begin
        logic [ENTRIES-1:0] avail;
        avail = ~valid;
        ack   = '0;
        for (int p = 0; p < PIPE; p++) alloc_idx[p] = '0;
        for (int p = 0; p < PIPE; p++) begin
            if (bus.miss_en[p] && rst && !bus.flush_en && (avail != '0)) begin
                ack[p] = 1'b1;
                for (int e = ENTRIES-1; e >= 0; e--)
                    if (avail[e]) alloc_idx[p] = EW'(e);
                avail[alloc_idx[p]] = 1'b0;
            end
        end
    end

    always_comb begin
        alloc_any = '0;
        new_match = '0;
        for (int p = 0; p < PIPE; p++)
            for (int e = 0; e < ENTRIES; e++)
                if (ack[p] && (alloc_idx[p] == EW'(e))) begin
                    alloc_any[e] = 1'b1;
                    if (port_line[p] == cmp_line) new_match[e] = 1'b1;
                end
    end

    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            line_hit[e] = valid[e] && (e_line[e] == cmp_line);
            squash[e]   = bus.flush_en && valid[e] && is_squashed(e_lqidx[e], bus.flush_lqidx);
        end
    end

    // Emission: up to REFILL_PORTS lowest pending entries that survive this cycle's flush.
    always_comb begin
        logic [ENTRIES-1:0] cand;
        cand      = (state == DRAIN) ? (pend & ~squash) : '0;
        emit_en   = '0;
        emit_mask = '0;
        for (int k = 0; k < REFILL_PORTS; k++) emit_idx[k] = '0;
        for (int k = 0; k < REFILL_PORTS; k++) begin
            for (int e = ENTRIES-1; e >= 0; e--)
                if (cand[e]) begin
                    emit_en[k]  = 1'b1;
                    emit_idx[k] = EW'(e);
                end
            if (emit_en[k]) begin
                cand[emit_idx[k]]      = 1'b0;
                emit_mask[emit_idx[k]] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        case (state)
            IDLE: begin
                pend_nxt = '0;
                if (hs) begin
                    pend_nxt  = (line_hit & ~squash) | new_match;
                    state_nxt = (pend_nxt != '0) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                pend_nxt  = (pend & ~emit_mask & ~squash) | new_match;
                state_nxt = (pend_nxt != '0) ? DRAIN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        valid_nxt = (valid & ~squash & ~emit_mask) | alloc_any;
    end

    // Stage p1: registered control and load-queue outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            valid    <= '0;
            pend     <= '0;
            lq_en_p1 <= '0;
            full_p1  <= 1'b0;
            for (int k = 0; k < REFILL_PORTS; k++) begin
                lq_idx_p1[k]  <= '0;
                lq_data_p1[k] <= '0;
            end
        end else begin
            state    <= state_nxt;
            valid    <= valid_nxt;
            pend     <= pend_nxt;
            full_p1  <= &valid_nxt;
            lq_en_p1 <= emit_en;
            for (int k = 0; k < REFILL_PORTS; k++)
                if (emit_en[k]) begin
                    lq_idx_p1[k]  <= e_lqidx[emit_idx[k]];
                    lq_data_p1[k] <= line_buf[e_word[emit_idx[k]]];
                end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < PIPE; p++)
            if (ack[p]) begin
                e_lqidx[alloc_idx[p]] <= bus.miss_lqidx[p*IW +: IW];
                e_line[alloc_idx[p]]  <= port_line[p];
                e_word[alloc_idx[p]]  <= bus.miss_paddr[p*ADDR_W+2 +: WW];
            end
        if (hs) begin
            cur_line <= bus.refill_addr;
            for (int w = 0; w < LINE_WORDS; w++) line_buf[w] <= bus.refill_data[w*32 +: 32];
        end
    end

`ifdef LRB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_refills <= '0;
            perf_nack    <= '0;
        end else begin
            if (hs && (pend_nxt != '0) && (perf_refills != '1)) perf_refills <= perf_refills + 32'd1;
            if ((|(bus.miss_en & ~ack)) && (perf_nack != '1)) perf_nack <= perf_nack + 32'd1;
        end
    end
`endif

    assign bus.miss_ack     = ack;
    assign bus.refill_ready = (state == IDLE);
    assign bus.lq_en        = lq_en_p1;
    assign bus.full         = full_p1;
    for (genvar k = 0; k < REFILL_PORTS; k++) begin : g_out
        assign bus.lq_idx[k*IW +: IW]  = lq_idx_p1[k];
        assign bus.lq_data[k*32 +: 32] = lq_data_p1[k];
    end
endmodule

// File: tb/tb_load_refill_buffer.sv
// Directed bench for load_refill_buffer: expected load-queue writes are queued at refill time
// and popped as the buffer emits them.
module tb_load_refill_buffer;
    localparam int PIPE = 2, RP = 2, LQ_W = 5, ADDR_W = 32, LWORDS = 16, IW = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    load_refill_buffer_if #(.PIPE(PIPE), .REFILL_PORTS(RP), .LQ_W(LQ_W),
                            .ADDR_W(ADDR_W), .LINE_WORDS(LWORDS)) bus ();

`ifdef LRB_PERF_CNT_EN
    logic [31:0] perf_refills, perf_nack;
`endif

    load_refill_buffer #(.ENTRIES(8), .PIPE(PIPE), .REFILL_PORTS(RP), .LQ_W(LQ_W),
                         .ADDR_W(ADDR_W), .LINE_WORDS(LWORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef LRB_PERF_CNT_EN
        ,
        .perf_refills (perf_refills),
        .perf_nack    (perf_nack)
`endif
    );

    typedef struct {
        logic [IW-1:0] idx;
        logic [31:0]   data;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and score any load-queue writes against the queue.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        for (int k = 0; k < RP; k++) begin
            if (bus.lq_en[k] === 1'b1) begin
                if (sb.size() == 0) begin
                    check("lq_en_unexpected", 64'(bus.lq_en[k]), 64'(1'b0));
                end else begin
                    e = sb.pop_front();
                    check("lq_idx", 64'(bus.lq_idx[k*IW +: IW]), 64'(e.idx));
                    check("lq_data", 64'(bus.lq_data[k*32 +: 32]), 64'(e.data));
                end
            end
        end
    endtask

    task automatic push_exp(input logic [IW-1:0] idx, input logic [31:0] paddr, input logic [31:0] base);
        exp_t e;
        e.idx  = idx;
        e.data = base + 32'(paddr[5:2]);
        sb.push_back(e);
    endtask

    task automatic miss(input logic [1:0] en, input logic [IW-1:0] i0, input logic [31:0] p0,
                        input logic [IW-1:0] i1, input logic [31:0] p1,
                        input logic [1:0] exp_ack, input string tag);
        bus.miss_en    = en;
        bus.miss_lqidx = {i1, i0};
        bus.miss_paddr = {p1, p0};
        #1;
        check(tag, 64'(bus.miss_ack), 64'(exp_ack));
        tick();
        bus.miss_en = '0;
    endtask

    task automatic refill(input logic [31:0] paddr, input logic [31:0] base);
        bus.refill_valid = 1'b1;
        bus.refill_addr  = paddr[31:6];
        for (int w = 0; w < LWORDS; w++) bus.refill_data[w*32 +: 32] = base + 32'(w);
        #1;
        check("refill_ready_pre", 64'(bus.refill_ready), 64'(1'b1));
        tick();
        bus.refill_valid = 1'b0;
    endtask

    logic [31:0] a1, a2, a3, a4, a5, a6, a7, a8;

    initial begin
        bus.miss_en      = 2'b11;
        bus.miss_lqidx   = '0;
        bus.miss_paddr   = '0;
        bus.refill_valid = 1'b0;
        bus.refill_addr  = '0;
        bus.refill_data  = '0;
        bus.flush_en     = 1'b0;
        bus.flush_lqidx  = '0;
        a1 = 32'h8000_0048; a2 = 32'h1234_5600; a3 = 32'h0000_1000; a4 = 32'h0000_2040;
        a5 = 32'h0004_0000; a6 = 32'h000C_0000; a7 = 32'h0008_0000; a8 = 32'h0010_0000;

        // Reset state
        tick();
        tick();
        check("rst_lq_en", 64'(bus.lq_en), 64'(2'b00));
        check("rst_lq_idx", 64'(bus.lq_idx), 64'(0));
        check("rst_lq_data", 64'(bus.lq_data), 64'(0));
        check("rst_refill_ready", 64'(bus.refill_ready), 64'(1'b1));
        check("rst_full", 64'(bus.full), 64'(1'b0));
        check("rst_miss_ack", 64'(bus.miss_ack), 64'(2'b00));
        bus.miss_en = '0;
        rst = 1'b1;
        tick();

        // Single miss, then refill two cycles later
        miss(2'b01, 6'h03, a1, 6'h00, 32'h0, 2'b01, "ack_single");
        tick();
        push_exp(6'h03, a1, 32'h1000);
        refill(a1, 32'h1000);
        check("lq_en_first_drain", 64'(bus.lq_en), 64'(2'b00));
        tick();
        check("lq_en_single", 64'(bus.lq_en), 64'(2'b01));
        check("rr_after_single", 64'(bus.refill_ready), 64'(1'b1));
        tick();
        check("lq_en_idle", 64'(bus.lq_en), 64'(2'b00));

        // Three misses to one line, words 0 / 5 / 15
        miss(2'b11, 6'h0A, a2, 6'h0B, a2 + 32'd20, 2'b11, "ack_three_a");
        miss(2'b01, 6'h0C, a2 + 32'd60, 6'h00, 32'h0, 2'b01, "ack_three_b");
        push_exp(6'h0A, a2, 32'h2000);
        push_exp(6'h0B, a2 + 32'd20, 32'h2000);
        push_exp(6'h0C, a2 + 32'd60, 32'h2000);
        refill(a2, 32'h2000);
        check("rr_three_0", 64'(bus.refill_ready), 64'(1'b0));
        tick();
        check("lq_en_three_1", 64'(bus.lq_en), 64'(2'b11));
        check("rr_three_1", 64'(bus.refill_ready), 64'(1'b0));
        tick();
        check("lq_en_three_2", 64'(bus.lq_en), 64'(2'b01));
        check("rr_three_2", 64'(bus.refill_ready), 64'(1'b1));

        // Full buffer, then seven valid entries
        miss(2'b11, 6'h10, a3,           6'h11, a3 + 32'd4,  2'b11, "ack_fill_0");
        miss(2'b11, 6'h12, a3 + 32'd8,   6'h13, a3 + 32'd12, 2'b11, "ack_fill_1");
        miss(2'b11, 6'h14, a3 + 32'd16,  6'h15, a3 + 32'd20, 2'b11, "ack_fill_2");
        miss(2'b11, 6'h16, a3 + 32'd24,  6'h17, a4 + 32'd8,  2'b11, "ack_fill_3");
        check("full_eight", 64'(bus.full), 64'(1'b1));
        bus.miss_en = 2'b11;
        #1;
        check("ack_full", 64'(bus.miss_ack), 64'(2'b00));
        bus.miss_en = '0;
        push_exp(6'h17, a4 + 32'd8, 32'h3000);
        refill(a4, 32'h3000);
        tick();
        check("lq_en_one_of_eight", 64'(bus.lq_en), 64'(2'b01));
        check("full_seven", 64'(bus.full), 64'(1'b0));
        miss(2'b11, 6'h18, a3 + 32'd28, 6'h19, a3 + 32'd32, 2'b01, "ack_seven");
        check("full_refilled", 64'(bus.full), 64'(1'b1));
        for (int i = 0; i < 7; i++) push_exp(IW'(6'h10 + i), a3 + 32'(4 * i), 32'h4000);
        push_exp(6'h18, a3 + 32'd28, 32'h4000);
        refill(a3, 32'h4000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lq_en_eight", 64'(bus.lq_en), 64'(2'b11));
        end
        check("rr_after_eight", 64'(bus.refill_ready), 64'(1'b1));
        check("full_after_eight", 64'(bus.full), 64'(1'b0));

        // Flush in the first drain cycle at {0,5}
        miss(2'b11, 6'h02, a5,          6'h04, a5 + 32'd4,  2'b11, "ack_flush_a");
        miss(2'b11, 6'h06, a5 + 32'd8,  6'h21, a5 + 32'd12, 2'b11, "ack_flush_b");
        push_exp(6'h02, a5, 32'h5000);
        push_exp(6'h04, a5 + 32'd4, 32'h5000);
        refill(a5, 32'h5000);
        bus.flush_en    = 1'b1;
        bus.flush_lqidx = 6'h05;
        bus.miss_en     = 2'b01;
        bus.miss_lqidx  = {6'h00, 6'h07};
        bus.miss_paddr  = {32'h0, a5 + 32'd16};
        #1;
        check("ack_during_flush", 64'(bus.miss_ack), 64'(2'b00));
        tick();
        bus.flush_en = 1'b0;
        bus.miss_en  = '0;
        check("lq_en_flush", 64'(bus.lq_en), 64'(2'b11));
        check("rr_flush", 64'(bus.refill_ready), 64'(1'b1));
        tick();
        check("lq_en_after_flush", 64'(bus.lq_en), 64'(2'b00));

        // Non-matching refill while one unrelated entry waits
        miss(2'b01, 6'h08, a7, 6'h00, 32'h0, 2'b01, "ack_wait");
        refill(a6, 32'h6000);
        check("lq_en_nomatch_0", 64'(bus.lq_en), 64'(2'b00));
        check("rr_nomatch_0", 64'(bus.refill_ready), 64'(1'b1));
        tick();
        check("lq_en_nomatch_1", 64'(bus.lq_en), 64'(2'b00));
        check("rr_nomatch_1", 64'(bus.refill_ready), 64'(1'b1));

        // Late joiner on the line being drained
        miss(2'b11, 6'h09, a7 + 32'd4, 6'h0A, a7 + 32'd8, 2'b11, "ack_late_pre");
        push_exp(6'h08, a7, 32'h7000);
        push_exp(6'h09, a7 + 32'd4, 32'h7000);
        push_exp(6'h0A, a7 + 32'd8, 32'h7000);
        push_exp(6'h0B, a7 + 32'd12, 32'h7000);
        refill(a7, 32'h7000);
        miss(2'b10, 6'h00, 32'h0, 6'h0B, a7 + 32'd12, 2'b10, "ack_late");
        check("lq_en_late_0", 64'(bus.lq_en), 64'(2'b11));
        tick();
        check("lq_en_late_1", 64'(bus.lq_en), 64'(2'b11));
        check("rr_late", 64'(bus.refill_ready), 64'(1'b1));

        // Reset asserted mid-drain
        miss(2'b11, 6'h0C, a8, 6'h0D, a8 + 32'd4, 2'b11, "ack_rst_a");
        miss(2'b01, 6'h0E, a8 + 32'd8, 6'h00, 32'h0, 2'b01, "ack_rst_b");
        push_exp(6'h0C, a8, 32'h8000);
        push_exp(6'h0D, a8 + 32'd4, 32'h8000);
        refill(a8, 32'h8000);
        tick();
        check("lq_en_rst_0", 64'(bus.lq_en), 64'(2'b11));
        rst = 1'b0;
        tick();
        check("lq_en_rst_1", 64'(bus.lq_en), 64'(2'b00));
        check("rr_rst", 64'(bus.refill_ready), 64'(1'b1));
        check("full_rst", 64'(bus.full), 64'(1'b0));
        rst = 1'b1;
        tick();
        check("lq_en_rst_2", 64'(bus.lq_en), 64'(2'b00));

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
